// File: rtl/ula_8_bits_driver.sv
// Command-side initiator for the combinational 8-bit ULA.
// Registers operands, waits a settle window, captures the result.
module ula_8_bits_driver #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [2:0]           CMD_OP,
  input  logic [WIDTH-1:0]     CMD_A,
  input  logic [WIDTH-1:0]     CMD_B,
  input  logic                 CMD_CIN,
  input  logic                 CMD_USE_ACC,
  output logic [WIDTH-1:0]     ULA_A,
  output logic [WIDTH-1:0]     ULA_B,
  output logic [2:0]           ULA_X,
  output logic                 ULA_CIN,
  input  logic [WIDTH-1:0]     ULA_S,
  input  logic                 ULA_COUT,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [WIDTH-1:0]     RSP_S,
  output logic                 RSP_COUT,
  output logic                 RSP_ZERO,
  output logic                 RSP_ERR,
  output logic [WIDTH-1:0]     ACC,
  output logic [CNT_WIDTH-1:0] OP_COUNT
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     ula_a_q, ula_a_d;
  logic [WIDTH-1:0]     ula_b_q, ula_b_d;
  logic [2:0]           ula_x_q, ula_x_d;
  logic                 ula_cin_q, ula_cin_d;
  logic [WIDTH-1:0]     rsp_s_q, rsp_s_d;
  logic                 rsp_cout_q, rsp_cout_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] opcnt_q, opcnt_d;
  logic                 op_ok;
  logic                 arith;

  assign op_ok = (CMD_OP <= 3'd4);
  assign arith = (ula_x_q == 3'd0) || (ula_x_q == 3'd1);

  // Next-state and datapath: accept, settle, capture, hand back
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ula_a_d    = ula_a_q;
    ula_b_d    = ula_b_q;
    ula_x_d    = ula_x_q;
    ula_cin_d  = ula_cin_q;
    rsp_s_d    = rsp_s_q;
    rsp_cout_d = rsp_cout_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    acc_d      = acc_q;
    opcnt_d    = opcnt_q;
    unique case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          if (op_ok) begin
            ula_a_d   = CMD_USE_ACC ? acc_q : CMD_A;
            ula_b_d   = CMD_B;
            ula_x_d   = CMD_OP;
            ula_cin_d = CMD_CIN;
            cnt_d     = SW'(SETTLE_CYCLES);
            state_d   = DRIVE;
          end else begin
            rsp_s_d    = '0;
            rsp_cout_d = 1'b0;
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == SW'(1)) begin
          rsp_s_d    = ULA_S;
          rsp_cout_d = arith ? ULA_COUT : 1'b0;
          rsp_zero_d = (ULA_S == '0);
          rsp_err_d  = 1'b0;
          acc_d      = ULA_S;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          opcnt_d = opcnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ula_a_q    <= '0;
      ula_b_q    <= '0;
      ula_x_q    <= '0;
      ula_cin_q  <= 1'b0;
      rsp_s_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      acc_q      <= '0;
      opcnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ula_a_q    <= ula_a_d;
      ula_b_q    <= ula_b_d;
      ula_x_q    <= ula_x_d;
      ula_cin_q  <= ula_cin_d;
      rsp_s_q    <= rsp_s_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
      acc_q      <= acc_d;
      opcnt_q    <= opcnt_d;
    end
  end

  assign CMD_READY = (state_q == IDLE) && RESET_N;
  assign RSP_VALID = (state_q == RESP);
  assign ULA_A     = ula_a_q;
  assign ULA_B     = ula_b_q;
  assign ULA_X     = ula_x_q;
  assign ULA_CIN   = ula_cin_q;
  assign RSP_S     = rsp_s_q;
  assign RSP_COUT  = rsp_cout_q;
  assign RSP_ZERO  = rsp_zero_q;
  assign RSP_ERR   = rsp_err_q;
  assign ACC       = acc_q;
  assign OP_COUNT  = opcnt_q;

endmodule

// File: tb/tb_ula_8_bits_driver.sv
// Bench for ula_8_bits_driver: directed cases plus random ops
// against an arithmetic reference of the whole transaction.
module tb_ula_8_bits_driver;

  localparam int S  = 3;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          CMD_VALID, CMD_READY;
  logic [2:0]    CMD_OP;
  logic [7:0]    CMD_A, CMD_B;
  logic          CMD_CIN, CMD_USE_ACC;
  logic [7:0]    ULA_A, ULA_B;
  logic [2:0]    ULA_X;
  logic          ULA_CIN;
  logic [7:0]    ULA_S;
  logic          ULA_COUT;
  logic          RSP_VALID, RSP_READY;
  logic [7:0]    RSP_S;
  logic          RSP_COUT, RSP_ZERO, RSP_ERR;
  logic [7:0]    ACC;
  logic [CW-1:0] OP_COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_acc, m_ua, m_ub;
  logic [2:0] m_ux;
  logic       m_uc;
  int         m_cnt;

  always #5 CLK = ~CLK;

  ula_8_bits_driver #(
    .WIDTH(8), .SETTLE_CYCLES(S), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_A(CMD_A), .CMD_B(CMD_B),
    .CMD_CIN(CMD_CIN), .CMD_USE_ACC(CMD_USE_ACC),
    .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_X(ULA_X),
    .ULA_CIN(ULA_CIN), .ULA_S(ULA_S), .ULA_COUT(ULA_COUT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_S(RSP_S), .RSP_COUT(RSP_COUT), .RSP_ZERO(RSP_ZERO),
    .RSP_ERR(RSP_ERR), .ACC(ACC), .OP_COUNT(OP_COUNT)
  );

  // Stand-in combinational ULA; carry out is junk on logic ops
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (ULA_X)
      3'd0: t = {1'b0, ULA_A} + {1'b0, ULA_B} + {8'd0, ULA_CIN};
      3'd1: t = {1'b0, ULA_A} - {1'b0, ULA_B} - {8'd0, ULA_CIN};
      3'd2: t = {^ULA_A, ULA_A & ULA_B};
      3'd3: t = {~^ULA_B, ULA_A | ULA_B};
      3'd4: t = {1'b1, ~ULA_A};
      default: t = 9'h155;
    endcase
    ULA_S    = t[7:0];
    ULA_COUT = t[8];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ula();
    check("ula_a", 32'(ULA_A), 32'(m_ua));
    check("ula_b", 32'(ULA_B), 32'(m_ub));
    check("ula_x", 32'(ULA_X), 32'(m_ux));
    check("ula_cin", 32'(ULA_CIN), 32'(m_uc));
  endtask

  task automatic model_reset();
    m_acc = '0; m_ua = '0; m_ub = '0; m_ux = '0; m_uc = 1'b0;
    m_cnt = 0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic cin,
                       input logic ua, input int dly);
    int ia, ib, ic, r, lat;
    logic [7:0] ea, es;
    logic ec, ez, ee;
    ee = (op > 3'd4);
    ea = ua ? m_acc : a;
    ia = int'(ea); ib = int'(b); ic = int'(cin);
    case (op)
      3'd0:    r = ia + ib + ic;
      3'd1:    r = ia - ib - ic;
      3'd2:    r = ia & ib;
      3'd3:    r = ia | ib;
      3'd4:    r = 255 - ia;
      default: r = 0;
    endcase
    es = ee ? 8'd0 : r[7:0];
    ec = (!ee && op <= 3'd1) ? r[8] : 1'b0;
    ez = !ee && (es == 8'd0);
    CMD_OP = op; CMD_A = a; CMD_B = b;
    CMD_CIN = cin; CMD_USE_ACC = ua; CMD_VALID = 1'b1;
    check("cmd_ready_idle", 32'(CMD_READY), 32'd1);
    @(posedge CLK); #1;
    CMD_VALID = $urandom_range(0, 1);
    CMD_OP = 3'($urandom); CMD_A = 8'($urandom); CMD_B = 8'($urandom);
    if (!ee) begin
      m_ua = ea; m_ub = b; m_ux = op; m_uc = cin;
    end
    check_ula();
    lat = 0;
    while (!RSP_VALID && lat < 50) begin
      check("cmd_ready_busy", 32'(CMD_READY), 32'd0);
      @(posedge CLK); #1;
      lat++;
    end
    check("latency", 32'(lat), ee ? 32'd0 : 32'(S));
    if (!ee) m_acc = es;
    check("rsp_s", 32'(RSP_S), 32'(es));
    check("rsp_cout", 32'(RSP_COUT), 32'(ec));
    check("rsp_zero", 32'(RSP_ZERO), 32'(ez));
    check("rsp_err", 32'(RSP_ERR), 32'(ee));
    check("acc_cap", 32'(ACC), 32'(m_acc));
    check_ula();
    for (int i = 0; i < dly; i++) begin
      @(posedge CLK); #1;
      check("hold_valid", 32'(RSP_VALID), 32'd1);
      check("hold_s", 32'(RSP_S), 32'(es));
      check("hold_ready", 32'(CMD_READY), 32'd0);
      check("hold_cnt", 32'(OP_COUNT), 32'(m_cnt % (1 << CW)));
    end
    CMD_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    m_cnt++;
    check("op_count", 32'(OP_COUNT), 32'(m_cnt % (1 << CW)));
    check("rsp_drop", 32'(RSP_VALID), 32'd0);
    check("cmd_ready_back", 32'(CMD_READY), 32'd1);
    check("acc", 32'(ACC), 32'(m_acc));
  endtask

  initial begin
    RESET_N = 1'b0; CMD_VALID = 1'b0; RSP_READY = 1'b0;
    CMD_OP = '0; CMD_A = '0; CMD_B = '0;
    CMD_CIN = 1'b0; CMD_USE_ACC = 1'b0;
    model_reset();
    #12;
    check("rst_ready", 32'(CMD_READY), 32'd0);
    check("rst_valid", 32'(RSP_VALID), 32'd0);
    check("rst_acc", 32'(ACC), 32'd0);
    check("rst_cnt", 32'(OP_COUNT), 32'd0);
    check_ula();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    #1;
    check("rel_ready", 32'(CMD_READY), 32'd1);

    do_op(3'd0, 8'h83, 8'h01, 1'b0, 1'b0, 0);
    do_op(3'd1, 8'h92, 8'h06, 1'b0, 1'b0, 1);
    do_op(3'd2, 8'h00, 8'hF0, 1'b0, 1'b1, 0);
    do_op(3'd4, 8'h00, 8'h5A, 1'b0, 1'b1, 5);
    do_op(3'd7, 8'h12, 8'h34, 1'b1, 1'b0, 2);
    do_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    check("acc_wrap_zero", 32'(ACC), 32'd0);

    for (int k = 0; k < 150; k++)
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 3));

    // Abort an op mid-settle
    CMD_OP = 3'd0; CMD_A = 8'h11; CMD_B = 8'h22;
    CMD_CIN = 1'b0; CMD_USE_ACC = 1'b0; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    model_reset();
    check("mid_ready", 32'(CMD_READY), 32'd0);
    check("mid_valid", 32'(RSP_VALID), 32'd0);
    check("mid_acc", 32'(ACC), 32'd0);
    check("mid_cnt", 32'(OP_COUNT), 32'd0);
    check("mid_s", 32'(RSP_S), 32'd0);
    check_ula();
    @(posedge CLK); #1;
    check("mid_ready2", 32'(CMD_READY), 32'd0);
    RESET_N = 1'b1;
    #1;
    check("post_ready", 32'(CMD_READY), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("post_valid", 32'(RSP_VALID), 32'd0);
    end
    do_op(3'd3, 8'h0F, 8'hA0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
